// File: rtl/mc_fifo_flex.sv
// Parametrised synchronous FIFO with valid/ready on both sides, any DEPTH >= 2,
// occupancy flags, synchronous flush and sticky overflow/underflow errors.
module mc_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  localparam int ADDR_W   = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_rdy_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_vld_o,
  output logic [CNT_W-1:0] count_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             ovf_o,
  output logic             udf_o
);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "mc_fifo_flex: DEPTH must be at least 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $fatal(1, "mc_fifo_flex: AFULL_TH must be within 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "mc_fifo_flex: AEMPTY_TH must be within 0..DEPTH-1");
  end

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AFULL_CNT = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0]  AEMPTY_CNT = CNT_W'(AEMPTY_TH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              udf;
  logic              push_acc;
  logic              pop_acc;

  assign push_rdy_o = (cnt < FULL_CNT);
  assign pop_vld_o  = (cnt != '0);
  assign push_acc   = push_i & push_rdy_o & ~flush_i;
  assign pop_acc    = pop_i & pop_vld_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (flush_i) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      // Explicit wrap keeps non-power-of-2 depths from aliasing.
      if (push_acc) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + ADDR_W'(1);
      if (pop_acc)  rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + ADDR_W'(1);
      if (push_acc && !pop_acc)      cnt <= cnt + CNT_W'(1);
      else if (pop_acc && !push_acc) cnt <= cnt - CNT_W'(1);
      if (push_i && !push_rdy_o) ovf <= 1'b1;
      if (pop_i && !pop_vld_o)   udf <= 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked by cnt alone.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_idx] <= push_data_i;
  end

  assign pop_data_o     = pop_vld_o ? mem[rd_idx] : '0;
  assign count_o        = cnt;
  assign almost_full_o  = (cnt >= AFULL_CNT);
  assign almost_empty_o = (cnt <= AEMPTY_CNT);
  assign ovf_o          = ovf;
  assign udf_o          = udf;

endmodule

// File: doc/mc_fifo_flex.md
# mc_fifo_flex

Parametrised synchronous FIFO for memory-controller command and data queues. It adds the following:
- any DEPTH ≥ 2, including non-power-of-2;
- a true valid/ready handshake on both sides;
- a live occupancy count with almost-full and almost-empty flags;
- a synchronous flush;
- sticky overflow and underflow error flags.

It sits between the host-side request decoder and the DDR command scheduler, and on the write and read data paths.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of entries (≥2; non-power-of-2 legal)
- AFULL_TH, DEPTH-1, almost_full_o asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 1, almost_empty_o asserts when count ≤ AEMPTY_TH (0..DEPTH-1)
- Derived: ADDR_W = max(1,$clog2(DEPTH)); CNT_W = $clog2(DEPTH+1)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of all queue state
- push_i  in  1  producer valid
- push_data_i  in  WIDTH  producer data
- push_rdy_o  out  1  FIFO can accept; equals (count < DEPTH)
- pop_i  in  1  consumer ready
- pop_data_o  out  WIDTH  head entry; '0 when pop_vld_o=0
- pop_vld_o  out  1  head valid; equals (count ≠ 0)
- count_o  out  CNT_W  current occupancy, 0..DEPTH
- almost_full_o  out  1  count ≥ AFULL_TH
- almost_empty_o  out  1  count ≤ AEMPTY_TH
- ovf_o  out  1  sticky overflow: push attempted while full
- udf_o  out  1  sticky underflow: pop attempted while empty

## Operation
- State: wr_idx and rd_idx (ADDR_W bits, range 0..DEPTH-1), cnt (CNT_W bits), ovf, udf, and memory mem[DEPTH].
- Memory is not reset. Read data is gated to '0 when the FIFO is empty.
- push_acc = push_i & push_rdy_o & ~flush_i.
- pop_acc = pop_i & pop_vld_o & ~flush_i.
- On push_acc: write mem[wr_idx] ← push_data_i. wr_idx advances to wr_idx==DEPTH-1 ? 0 : wr_idx+1 (explicit wrap, never modulo-2^ADDR_W).
- On pop_acc: rd_idx advances with the same wrap rule.
- cnt update: +1 on push only, −1 on pop only, unchanged on both or neither.
- pop_data_o = mem[rd_idx] (first-word-fall-through) when cnt ≠ 0.
- Full (cnt = DEPTH) with push_i and pop_i both high:
  - pop accepted, push rejected (push_rdy_o is already 0);
  - ovf sets;
  - next cnt = DEPTH-1.
- Empty (cnt = 0) with push_i and pop_i both high:
  - push accepted, pop rejected;
  - udf sets;
  - next cnt = 1. No bypass: data is never popped in the cycle it is pushed.
- ovf sets on push_i & ~push_rdy_o & ~flush_i. udf sets on pop_i & ~pop_vld_o & ~flush_i. Both hold until flush or reset.
- flush_i has priority over push and pop. Next state: wr_idx = rd_idx = cnt = 0, ovf = udf = 0. Memory contents are unchanged and unobservable.
- Flags and status outputs are combinational decodes of registered cnt, ovf and udf only. No input-to-output combinational path except pop_data_o ← memory read.
- Elaboration checks (fatal): DEPTH<2, AFULL_TH outside 1..DEPTH, AEMPTY_TH outside 0..DEPTH-1.

## Timing
- Reset values (asynchronous assert; release synchronous to clk_i):
  - push_rdy_o=1, pop_vld_o=0, pop_data_o='0, count_o=0
  - almost_full_o=(AFULL_TH==0 ? 1 : 0), which is always 0 for legal AFULL_TH
  - almost_empty_o=1, ovf_o=0, udf_o=0
- Push-to-pop latency is 1 cycle. A word accepted at edge N is visible on pop_data_o with pop_vld_o=1 after edge N, so it can be popped at edge N+1.
- The pop handshake completes at the edge where pop_i & pop_vld_o. The next head appears after that edge.
- Sustained throughput is 1 push and 1 pop per cycle whenever 0 < cnt < DEPTH.
- Flags, count_o, ovf_o and udf_o all reflect the state after the most recent edge. They never reflect the current-cycle request.
- Reset mid-operation discards all contents immediately. Outputs take reset values without waiting for a clock edge.

## Test plan
- Reset, then fill with DEPTH=5, WIDTH=8, AFULL_TH=4, AEMPTY_TH=1. Push 0x11..0x55 on 5 consecutive cycles:
  - count_o steps 1..5;
  - almost_empty_o drops at count 2;
  - almost_full_o rises at count 4;
  - push_rdy_o=0 at count 5.
  Then pop 5 times: data 0x11..0x55 in order, pop_vld_o=0 after the last pop.
- Wrap-around at DEPTH=5: run 13 cycles of simultaneous push/pop at count 2 with an incrementing pattern. Output must match input order exactly, count_o must stay at 2, and no ovf_o/udf_o.
- Full corner: at count 5, assert push_i=1 (0xAA) and pop_i=1 for one cycle.
  - Head is popped, 0xAA is dropped, count_o=4, ovf_o=1.
  - ovf_o stays 1 over the next 10 idle cycles.
- Empty corner: at count 0, assert push_i=1 (0x3C) and pop_i=1 for one cycle.
  - Next cycle: count_o=1, pop_vld_o=1, pop_data_o=0x3C, udf_o=1.
- Flush priority: at count 3 with ovf_o=1, assert flush_i with push_i and pop_i high.
  - Next cycle: count_o=0, pop_data_o=0, ovf_o=0, udf_o=0, push_rdy_o=1.
  - The flushed push is not present.
- Async reset: assert rst_n_i low mid-burst at count 3, between clock edges. All outputs take reset values immediately. After release, the first push of 0x77 pops as 0x77.
